// File: rtl/hex_display_ctrl_pkg.sv
// rtl/hex_display_ctrl_pkg.sv - shared states, glyph table and blank code for the hex display controller
package hex_display_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHOW   = 2'd2,
        SCROLL = 2'd3
    } state_t;

    // Active-low segments, bit k drives segment k (a..g)
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        return GLYPH_TABLE[nib];
    endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// rtl/disp_tick_gen.sv - free-running divider producing a one-cycle tick every TICK_DIV cycles
module disp_tick_gen #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..TICK_DIV-1, held at zero while cleared
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_MAX) && !clear;

endmodule

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - static/scrolling hex message controller for seven-segment digits; optional blink via HEXCTRL_BLINK_EN
module hex_display_ctrl
    import hex_display_ctrl_pkg::*;
#(
    parameter int DIGITS      = 6,
    parameter int MSG_NIBBLES = 8,
    parameter int TICK_DIV    = 12_500_000
) (
`ifdef HEXCTRL_BLINK_EN
    input  logic                     blink,
`endif
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [4*MSG_NIBBLES-1:0] wr_data,
    input  logic                     wr_scroll,
    input  logic                     lz_en,
    input  logic                     clr,
    output logic [7*DIGITS-1:0]      seg_out,
    output logic                     busy
);

    localparam int OFF_W = (MSG_NIBBLES > 1) ? $clog2(MSG_NIBBLES) : 1;
    localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(MSG_NIBBLES - 1);

    state_t                   state;
    logic [4*MSG_NIBBLES-1:0] msg;
    logic                     mode;
    logic [OFF_W-1:0]         offset;
    logic [OFF_W-1:0]         offset_next;
    logic [7*DIGITS-1:0]      seg_next;
    logic                     step_tick;
    logic                     accept;
    logic                     hide;

    assign wr_ready = !reset && (state != LOAD);
    assign accept   = wr_valid && wr_ready && !clr;
    assign busy     = (state == SHOW) || (state == SCROLL);

    disp_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_step_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state != SCROLL),
        .tick  (step_tick)
    );

`ifdef HEXCTRL_BLINK_EN
    logic blink_phase;
    logic blink_phase_next;
    logic blink_tick;

    disp_tick_gen #(
        .TICK_DIV (2 * TICK_DIV)
    ) u_blink_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state == LOAD),
        .tick  (blink_tick)
    );

    assign blink_phase_next = (state == LOAD) ? 1'b0 :
                              (blink_tick ? !blink_phase : blink_phase);
    assign hide = blink && blink_phase_next && ((state == SHOW) || (state == SCROLL));

    // Blink phase: 0 = content visible, restarts visible on every load
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_phase <= 1'b0;
        end else begin
            blink_phase <= blink_phase_next;
        end
    end
`else
    assign hide = 1'b0;
`endif

    // Offset the display will use after this edge; only SCROLL advances it
    always_comb begin
        offset_next = '0;
        if (state == SCROLL) begin
            if (step_tick) begin
                offset_next = (offset == OFF_MAX) ? '0 : offset + OFF_W'(1);
            end else begin
                offset_next = offset;
            end
        end
    end

    // Next segment image: digit i shows nibble (offset+i) mod MSG_NIBBLES, with optional leading-zero blanking
    always_comb begin
        logic       lz_active;
        logic       seen_nonzero;
        logic [3:0] nib;
        int         idx;
        seg_next     = '1;
        lz_active    = lz_en && ((state == SHOW) || ((state == LOAD) && !mode));
        seen_nonzero = 1'b0;
        nib          = '0;
        idx          = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            idx = (int'(offset_next) + i) % MSG_NIBBLES;
            nib = msg[4*idx +: 4];
            if (nib != 4'd0) begin
                seen_nonzero = 1'b1;
            end
            if (lz_active && !seen_nonzero && (i != 0)) begin
                seg_next[7*i +: 7] = SEG_BLANK;
            end else begin
                seg_next[7*i +: 7] = hex_glyph(nib);
            end
        end
        if (clr || (state == IDLE) || hide) begin
            seg_next = '1;
        end
    end

    // Controller FSM with registered message, offset and segment outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            msg     <= '0;
            mode    <= 1'b0;
            offset  <= '0;
            seg_out <= '1;
        end else begin
            offset  <= offset_next;
            seg_out <= seg_next;
            if (clr) begin
                state <= IDLE;
            end else if (accept) begin
                msg   <= wr_data;
                mode  <= wr_scroll;
                state <= LOAD;
            end else begin
                case (state)
                    LOAD:    state <= mode ? SCROLL : SHOW;
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - scoreboard bench for hex_display_ctrl
module tb_hex_display_ctrl;

    localparam int DIGITS      = 6;
    localparam int MSG_NIBBLES = 8;
    localparam int TICK_DIV    = 4;

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [6:0]  BL    = 7'b1111111;
    localparam logic [41:0] BLANK = {42{1'b1}};

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        wr_scroll;
    logic        lz_en;
    logic        clr;
    logic [41:0] seg_out;
    logic        busy;
`ifdef HEXCTRL_BLINK_EN
    logic        blink;
`endif

    hex_display_ctrl #(
        .DIGITS      (DIGITS),
        .MSG_NIBBLES (MSG_NIBBLES),
        .TICK_DIV    (TICK_DIV)
    ) dut (
`ifdef HEXCTRL_BLINK_EN
        .blink     (blink),
`endif
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_scroll (wr_scroll),
        .lz_en     (lz_en),
        .clr       (clr),
        .seg_out   (seg_out),
        .busy      (busy)
    );

    typedef struct {
        int          stamp;
        logic [41:0] seg;
        logic        busy;
        logic        ready;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [41:0] st_lz;
    logic [41:0] st_nolz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [41:0] scroll_exp(input int base, input int o);
        logic [41:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[7*i +: 7] = HEX[base + ((o + i) % MSG_NIBBLES)];
        end
        return r;
    endfunction

    task automatic expect_at(input int k, input logic [41:0] s, input logic b,
                             input logic r, input string n);
        exp_t e;
        e.stamp = cyc + k;
        e.seg   = s;
        e.busy  = b;
        e.ready = r;
        e.name  = n;
        q.push_back(e);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: count edges and compare DUT outputs 1 time unit after each edge
    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        #1;
        while (q.size() > 0 && q[0].stamp <= cyc) begin
            e = q.pop_front();
            checks = checks + 1;
            if (e.stamp != cyc || seg_out !== e.seg || busy !== e.busy || wr_ready !== e.ready) begin
                errors = errors + 1;
                $display("FAIL %s @%0d: seg=%h busy=%b ready=%b, want seg=%h busy=%b ready=%b",
                         e.name, e.stamp, seg_out, busy, wr_ready, e.seg, e.busy, e.ready);
            end
        end
    end

    initial begin
        st_lz   = {BL, BL, BL, BL, HEX[1], HEX[0]};
        st_nolz = {HEX[0], HEX[0], HEX[0], HEX[0], HEX[1], HEX[0]};
        reset = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_scroll = 1'b0;
        lz_en = 1'b0; clr = 1'b0;
`ifdef HEXCTRL_BLINK_EN
        blink = 1'b0;
`endif
        wait_neg(2);
        expect_at(1, BLANK, 1'b0, 1'b0, "reset");
        wait_neg(1);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) expect_at(k, BLANK, 1'b0, 1'b1, "idle");
        wait_neg(5);

        // static write with leading-zero blanking, then without
        wr_valid = 1'b1; wr_data = 32'h0000_0010; wr_scroll = 1'b0; lz_en = 1'b1;
        expect_at(1, BLANK, 1'b0, 1'b0, "static_load");
        expect_at(2, st_lz, 1'b1, 1'b1, "static_lz");
        wait_neg(1);
        wr_valid = 1'b0;
        wait_neg(1);
        lz_en = 1'b0;
        expect_at(1, st_nolz, 1'b1, 1'b1, "static_nolz");
        wait_neg(1);

        // scroll write issued from SHOW; full revolution including the wrap
        wr_valid = 1'b1; wr_data = 32'h7654_3210; wr_scroll = 1'b1;
        expect_at(1, st_nolz, 1'b0, 1'b0, "scroll_load");
        for (int k = 2; k <= 37; k++)
            expect_at(k, scroll_exp(0, ((k - 2) / TICK_DIV) % MSG_NIBBLES), 1'b1, 1'b1,
                      $sformatf("scroll_k%0d", k));
        wait_neg(1);
        wr_valid = 1'b0;
        wait_neg(36);

        // clr wins over a simultaneous write
        clr = 1'b1; wr_valid = 1'b1; wr_data = 32'hFFFF_FFFF; wr_scroll = 1'b0;
        expect_at(1, BLANK, 1'b0, 1'b1, "clr_idle");
        wait_neg(1);
        clr = 1'b0; wr_valid = 1'b0;
        expect_at(1, BLANK, 1'b0, 1'b1, "clr_no_write1");
        expect_at(2, BLANK, 1'b0, 1'b1, "clr_no_write2");
        wait_neg(2);

        // reset mid-scroll, then a fresh write starts at offset 0
        wr_valid = 1'b1; wr_data = 32'h7654_3210; wr_scroll = 1'b1;
        expect_at(1, BLANK, 1'b0, 1'b0, "rs_load");
        expect_at(2, scroll_exp(0, 0), 1'b1, 1'b1, "rs_first");
        wait_neg(1);
        wr_valid = 1'b0;
        wait_neg(6);
        reset = 1'b1; wr_valid = 1'b1; wr_data = 32'h1111_1111; wr_scroll = 1'b0;
        expect_at(1, BLANK, 1'b0, 1'b0, "rs_mid");
        wait_neg(1);
        reset = 1'b0; wr_valid = 1'b1; wr_data = 32'hFEDC_BA98; wr_scroll = 1'b1;
        expect_at(1, BLANK, 1'b0, 1'b0, "rs_new_load");
        for (int k = 2; k <= 7; k++)
            expect_at(k, scroll_exp(8, (k - 2) / TICK_DIV), 1'b1, 1'b1,
                      $sformatf("rs_new_k%0d", k));
        wait_neg(1);
        wr_valid = 1'b0;
        wait_neg(6);

`ifdef HEXCTRL_BLINK_EN
        clr = 1'b1;
        expect_at(1, BLANK, 1'b0, 1'b1, "blink_clr");
        wait_neg(1);
        clr = 1'b0; blink = 1'b1;
        wr_valid = 1'b1; wr_data = 32'h0000_0010; wr_scroll = 1'b0; lz_en = 1'b1;
        expect_at(1, BLANK, 1'b0, 1'b0, "blink_load");
        for (int k = 2; k <= 25; k++)
            expect_at(k, (((k - 2) / (2 * TICK_DIV)) % 2 == 1) ? BLANK : st_lz, 1'b1, 1'b1,
                      $sformatf("blink_k%0d", k));
        wait_neg(1);
        wr_valid = 1'b0;
        wait_neg(24);
        blink = 1'b0;
`endif

        for (int n = 0; n < 100 && q.size() > 0; n++) @(negedge clk);
        if (q.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- DIGITS, 6, number of seven-segment digits driven.
- MSG_NIBBLES, 8, nibbles in the message buffer; must be >= DIGITS.
- TICK_DIV, 12_500_000, clk cycles per scroll step.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- reset, in, 1, synchronous, active-high.
- wr_valid, in, 1, message write request.
- wr_ready, out, 1, controller accepts a write this cycle.
- wr_data, in, 4*MSG_NIBBLES, message; nibble 0 = LSBs.
- wr_scroll, in, 1, sampled with write: 1 = scroll mode, 0 = static mode.
- lz_en, in, 1, leading-zero blanking in static mode.
- clr, in, 1, blank the display and return to IDLE.
- seg_out, out, 7*DIGITS, segments; digit i at bits [7i+6:7i]; within a digit, bit k = segment k (0..6 = a..g); active-low.
- busy, out, 1, high in SHOW or SCROLL.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, SHOW, SCROLL.
REQ-004 A write SHALL be accepted on an edge where wr_valid && wr_ready; data and mode SHALL be latched and the state SHALL go to LOAD.
REQ-005 wr_ready SHALL be 1 in IDLE, SHOW and SCROLL, 0 in LOAD, and 0 while reset is high.
REQ-006 The LOAD state SHALL last exactly one cycle, clear the scroll offset and tick counter, and then go to SCROLL if the latched mode is 1, else to SHOW.
REQ-007 seg_out SHALL be registered and SHALL show new content on the second edge after acceptance.
REQ-008 Digit i SHALL display nibble (offset+i) mod MSG_NIBBLES, using active-low hex glyphs 0-F.
REQ-009 In SCROLL, the tick counter SHALL count 0..TICK_DIV-1; at terminal count, offset SHALL increment and wrap from MSG_NIBBLES-1 to 0.
REQ-010 The first scroll step SHALL take effect exactly TICK_DIV cycles after LOAD.
REQ-011 In SHOW, offset SHALL stay 0 and the tick counter SHALL be held at 0.
REQ-012 In SHOW with lz_en=1, every zero digit above the most-significant non-zero displayed digit SHALL be blank (all segments 1); digit 0 SHALL never blank; blanking SHALL NOT apply in SCROLL.
REQ-013 In IDLE, seg_out SHALL be all ones.
REQ-014 clr SHALL force IDLE on the next edge from any state and SHALL override a simultaneous write.
REQ-015 A write accepted in SHOW or SCROLL SHALL fully replace the message and mode; no partial update is permitted.

Reset
REQ-016 While reset is high at an edge: state = IDLE, offset = 0, tick counter = 0, message = 0, seg_out = all ones, busy = 0.
REQ-017 A reset asserted mid-scroll SHALL discard the message; no write SHALL be accepted on a reset edge.

Configuration
REQ-018 With HEXCTRL_BLINK_EN defined:
- Add input blink (1 bit).
- In SHOW or SCROLL with blink=1, seg_out SHALL alternate between content and all ones, toggling every 2*TICK_DIV cycles from a free-running phase.
- The phase SHALL reset to "content visible" on reset and on LOAD.
REQ-019 Without HEXCTRL_BLINK_EN, the blink port and its logic SHALL be absent and behaviour SHALL be as blink=0.

Structure
REQ-020 A shared package SHALL hold:
- The state enum.
- The 16-entry active-low glyph table.
- The SEG_BLANK constant (7'b1111111).
REQ-021 The tick counter SHALL be a sub-module, disp_tick_gen, with clk, reset, clear and tick pulse output, parameterised by TICK_DIV.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then idle 5 cycles -> seg_out all ones, wr_ready=1, busy=0.
- Static write 0x00000010, lz_en=1 -> after 2 edges, digit0=0000001, digit1=1001111, digits 2-5 all ones; with lz_en=0, digits 2-5 show 0000001.
- Scroll write 0x76543210, TICK_DIV=4 -> digit0 shows 0,1,...,7,0 at 4-cycle intervals; the first change occurs 4 cycles after LOAD, and the wrap 7->0 is checked.
- clr and wr_valid asserted together in SCROLL -> IDLE, seg_out all ones, write not accepted.
- Reset asserted mid-scroll -> all REQ-016 values on the next edge; a new write then starts with offset 0.
- With HEXCTRL_BLINK_EN defined and blink=1, TICK_DIV=4 -> seg_out alternates content/blank every 8 cycles, starting with content at LOAD.
